// File: rtl/sm_mdu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer and the control decode.
// Holds the MDU op codes, the sequencer state encoding and the SPECIAL-class
// function codes that select the MDU instructions.
package sm_mdu_seq_pkg;

    // Operation select carried from the control unit.
    localparam logic MDU_MULTU = 1'b0;
    localparam logic MDU_DIVU  = 1'b1;

    // Sequencer states.
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    // SPECIAL-opcode function fields decoded by sm_control.
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1b;

endpackage

// File: rtl/sm_mdu_step.sv
// One shift/add (MULTU) or shift/subtract (DIVU, restoring) iteration.
// Purely combinational.
// Ports: i_op selects the operation; i_pr/i_q are the current upper/lower
//        work words; i_b is the multiplier or divisor; o_pr/o_q are the next words.
module sm_mdu_step
    import sm_mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_pr,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_pr,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_sum;    // P + (Q[0] ? B : 0), carry in the top bit
    logic [WIDTH:0]   w_rsh;    // {R,Q} shifted left: R needs one extra bit
    logic [WIDTH+1:0] w_diff;   // w_rsh - B; top bit is the borrow

    always_comb begin
        w_sum  = {1'b0, i_pr} + (i_q[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
        w_rsh  = {i_pr, i_q[WIDTH-1]};
        w_diff = {1'b0, w_rsh} - {2'b00, i_b};
        o_pr   = i_pr;
        o_q    = i_q;
        if (i_op == MDU_MULTU) begin
            // Shift {carry, sum, Q} right by one.
            o_pr = w_sum[WIDTH:1];
            o_q  = {w_sum[0], i_q[WIDTH-1:1]};
        end else begin
            // The remainder always stays below B, so either branch fits in WIDTH bits.
            if (!w_diff[WIDTH+1]) begin
                o_pr = w_diff[WIDTH-1:0];
                o_q  = {i_q[WIDTH-2:0], 1'b1};
            end else begin
                o_pr = w_rsh[WIDTH-1:0];
                o_q  = {i_q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/sm_mdu_seq.sv
// Iterative unsigned MULTU/DIVU sequencer with architectural HI/LO registers.
// Latency WIDTH+1 cycles from the start cycle to the done pulse; busy while running.
// Ports: i_clk/i_rst (sync, active-high); i_start/i_op/i_src_a/i_src_b launch an op;
//        i_wr_hi/i_wr_lo/i_wd are MTHI/MTLO; o_busy, o_done pulse, o_hi, o_lo.
module sm_mdu_seq
    import sm_mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wd,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_t       r_state;
    mdu_state_t       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_pr;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_idle_or_done;
    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [WIDTH-1:0] w_pr_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    sm_mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_op (r_op),
        .i_pr (r_pr),
        .i_q  (r_q),
        .i_b  (r_b),
        .o_pr (w_pr_nxt),
        .o_q  (w_q_nxt)
    );

    assign w_idle_or_done = (r_state == MDU_IDLE) || (r_state == MDU_DONE);
    assign w_accept       = i_start && w_idle_or_done;
    assign w_run          = (r_state == MDU_RUN);
    assign w_last         = w_run && (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MDU_IDLE: if (i_start) w_state_nxt = MDU_RUN;
            MDU_RUN:  if (w_last)  w_state_nxt = MDU_DONE;
            MDU_DONE: w_state_nxt = i_start ? MDU_RUN : MDU_IDLE;
            default:  w_state_nxt = MDU_IDLE;
        endcase
    end

    // Control state and the architectural registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_cnt <= '0;
            else if (w_run)
                r_cnt <= r_cnt + CW'(1);
            // A completing result takes priority; MTHI/MTLO are dropped while running.
            if (w_last) begin
                r_hi <= w_pr_nxt;
                r_lo <= w_q_nxt;
            end else if (w_idle_or_done) begin
                if (i_wr_hi) r_hi <= i_wd;
                if (i_wr_lo) r_lo <= i_wd;
            end
        end
    end

    // Work registers carry no state across reset; they are reloaded on accept.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_op <= i_op;
            r_pr <= '0;
            r_q  <= i_src_a;
            r_b  <= i_src_b;
        end else if (w_run) begin
            r_pr <= w_pr_nxt;
            r_q  <= w_q_nxt;
        end
    end

    assign o_busy = w_run;
    assign o_done = (r_state == MDU_DONE);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_sm_mdu_seq.sv
module tb_sm_mdu_seq;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        i_op;
    logic [31:0] i_src_a;
    logic [31:0] i_src_b;
    logic        i_wr_hi;
    logic        i_wr_lo;
    logic [31:0] i_wd;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int errors = 0;
    int checks = 0;

    sm_mdu_seq #(.WIDTH(32)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_op    (i_op),
        .i_src_a (i_src_a),
        .i_src_b (i_src_b),
        .i_wr_hi (i_wr_hi),
        .i_wr_lo (i_wr_lo),
        .i_wd    (i_wd),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (op == 1'b0)
            r = {32'd0, a} * {32'd0, b};
        else if (b == 32'd0)
            r = {a, 32'hFFFF_FFFF};
        else
            r = {a % b, a / b};
        return r;
    endfunction

    // poke: 0 none, 1 start pulse with other operands, 2 MTLO write; at run cycle poke_at.
    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input int poke, input int poke_at);
        logic [63:0] exp;
        logic [31:0] lo_pre;
        int n;
        int nbusy;
        exp     = model(op, a, b);
        lo_pre  = o_lo;
        i_op    = op;
        i_src_a = a;
        i_src_b = b;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 1;
        nbusy = 0;
        while (!o_done && n < 100) begin
            if (o_busy) nbusy++;
            if (poke == 1 && n == poke_at) begin
                i_start = 1'b1;
                i_op    = ~op;
                i_src_a = ~a;
                i_src_b = b + 32'd3;
            end
            if (poke == 2 && n == poke_at) begin
                i_wr_lo = 1'b1;
                i_wd    = 32'hDEAD_BEEF;
            end
            tick();
            if (poke == 2 && n == poke_at) begin
                i_wr_lo = 1'b0;
                check({tag, " lo unchanged by MTLO in RUN"}, {32'd0, o_lo}, {32'd0, lo_pre});
            end
            i_start = 1'b0;
            i_op    = op;
            i_src_a = a;
            i_src_b = b;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " busy cycles"}, 64'(nbusy), 64'd32);
        check({tag, " hi"}, {32'd0, o_hi}, {32'd0, exp[63:32]});
        check({tag, " lo"}, {32'd0, o_lo}, {32'd0, exp[31:0]});
    endtask

    initial begin
        logic [63:0] exp1;
        logic [63:0] exp2;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rop;
        int          n;
        int          ndone;

        i_rst = 1'b1; i_start = 1'b0; i_op = 1'b0; i_src_a = '0; i_src_b = '0;
        i_wr_hi = 1'b0; i_wr_lo = 1'b0; i_wd = '0;
        tick(); tick();
        check("reset busy", {63'd0, o_busy}, 64'd0);
        check("reset done", {63'd0, o_done}, 64'd0);
        check("reset hi", {32'd0, o_hi}, 64'd0);
        check("reset lo", {32'd0, o_lo}, 64'd0);
        i_rst = 1'b0;
        tick();

        // MTHI in IDLE.
        i_wr_hi = 1'b1; i_wd = 32'hA5A5_A5A5;
        tick();
        i_wr_hi = 1'b0;
        check("mthi idle hi", {32'd0, o_hi}, 64'h0000_0000_A5A5_A5A5);
        check("mthi idle lo", {32'd0, o_lo}, 64'd0);
        tick();

        run_op("multu 3x5", 1'b0, 32'd3, 32'd5, 0, 0);
        tick();
        run_op("multu max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op("divu 100/7", 1'b1, 32'd100, 32'd7, 0, 0);
        run_op("divu by0", 1'b1, 32'h1234, 32'd0, 0, 0);
        tick();
        run_op("start midrun", 1'b0, 32'h0001_2345, 32'h0000_0777, 1, 10);
        run_op("mtlo midrun", 1'b1, 32'hCAFE_F00D, 32'h0000_1001, 2, 7);
        tick();

        // Back-to-back: start held in the DONE cycle launches the next op.
        exp1 = model(1'b0, 32'h8000_0001, 32'h0000_0003);
        exp2 = model(1'b1, 32'hFFFF_0000, 32'h0000_00FF);
        i_op = 1'b0; i_src_a = 32'h8000_0001; i_src_b = 32'h0000_0003; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 1;
        while (!o_done && n < 100) begin tick(); n++; end
        check("b2b first latency", 64'(n), 64'd33);
        check("b2b first result", {o_hi, o_lo}, exp1);
        i_op = 1'b1; i_src_a = 32'hFFFF_0000; i_src_b = 32'h0000_00FF; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 1;
        while (!o_done && n < 100) begin tick(); n++; end
        check("b2b done spacing", 64'(n), 64'd33);
        check("b2b second result", {o_hi, o_lo}, exp2);
        tick();

        // Randomized operations.
        for (int k = 0; k < 16; k++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op($sformatf("rand%0d", k), rop, ra, rb, 0, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Reset in the middle of RUN.
        i_op = 1'b0; i_src_a = 32'h1111_1111; i_src_b = 32'h2222_2222; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("rst midrun busy", {63'd0, o_busy}, 64'd0);
        check("rst midrun done", {63'd0, o_done}, 64'd0);
        check("rst midrun hi", {32'd0, o_hi}, 64'd0);
        check("rst midrun lo", {32'd0, o_lo}, 64'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (o_done) ndone++;
        end
        check("rst midrun no done", 64'(ndone), 64'd0);
        run_op("after rst", 1'b1, 32'd1000, 32'd33, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
